// File: rtl/shf_pkg.sv
// Shared constants for the iterative shifter: mode codes, flag bit positions
// and the control FSM state encoding.
package shf_pkg;

  localparam logic [3:0] SHF_SHL = 4'd0;
  localparam logic [3:0] SHF_SHR = 4'd1;
  localparam logic [3:0] SHF_SCL = 4'd2;
  localparam logic [3:0] SHF_SCR = 4'd3;
  localparam logic [3:0] SHF_SAL = 4'd4;
  localparam logic [3:0] SHF_SAR = 4'd5;
  localparam logic [3:0] SHF_ROL = 4'd6;
  localparam logic [3:0] SHF_ROR = 4'd7;
  localparam logic [3:0] SHF_RCL = 4'd8;
  localparam logic [3:0] SHF_RCR = 4'd9;

  localparam int FLG_CF = 15;
  localparam int FLG_OF = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } shf_state_t;

endpackage

// File: rtl/shf_step.sv
// Single-bit shift/rotate step. Purely combinational: given the working
// register, carry and overflow, produce their values after one step.
module shf_step
  import shf_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_r,
  input  logic             i_c,
  input  logic             i_of,
  input  logic [3:0]       i_mode,
  output logic [WIDTH-1:0] o_r,
  output logic             o_c,
  output logic             o_of
);

  // Next-step data and flags; codes 10-15 leave everything untouched.
  always_comb begin
    o_r  = i_r;
    o_c  = i_c;
    o_of = i_of;
    case (i_mode)
      SHF_SHL: o_r = {i_r[WIDTH-2:0], 1'b0};
      SHF_SHR: o_r = {1'b0, i_r[WIDTH-1:1]};
      SHF_SCL: begin
        o_r = {i_r[WIDTH-2:0], 1'b0};
        o_c = i_r[WIDTH-1];
      end
      SHF_SCR: begin
        o_r = {1'b0, i_r[WIDTH-1:1]};
        o_c = i_r[0];
      end
      SHF_SAL: begin
        o_r  = {i_r[WIDTH-2:0], 1'b0};
        o_c  = i_r[WIDTH-1];
        // Sticky: once the sign would have changed, stay set.
        o_of = i_of | (i_r[WIDTH-1] ^ i_r[WIDTH-2]);
      end
      SHF_SAR: begin
        o_r  = {i_r[WIDTH-1], i_r[WIDTH-1:1]};
        o_c  = i_r[0];
        o_of = 1'b0;
      end
      SHF_ROL: o_r = {i_r[WIDTH-2:0], i_r[WIDTH-1]};
      SHF_ROR: o_r = {i_r[0], i_r[WIDTH-1:1]};
      SHF_RCL: begin
        o_r = {i_r[WIDTH-2:0], i_c};
        o_c = i_r[WIDTH-1];
      end
      SHF_RCR: begin
        o_r = {i_c, i_r[WIDTH-1:1]};
        o_c = i_r[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/shf_iter.sv
// Iterative shift/rotate engine: one single-bit step per clock under a
// start/busy/done handshake. Outputs show the working register directly, so
// intermediate step values are visible and the last result is held in IDLE.
module shf_iter
  import shf_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SHF_START,
  input  logic [WIDTH-1:0] SHF_IN,
  input  logic [CNT_W-1:0] SHF_TIMES,
  input  logic [3:0]       SHF_MODE,
  input  logic [15:0]      SHF_FLAG_in,
  output logic             SHF_BUSY,
  output logic             SHF_DONE,
  output logic [WIDTH-1:0] SHF_OUT,
  output logic [15:0]      SHF_FLAG_out
);

  shf_state_t       r_state;
  shf_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [15:0]      r_flag;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_mode;
  logic             w_accept;
  logic [WIDTH-1:0] w_r;
  logic             w_c;
  logic             w_of;

  assign w_accept = (r_state == ST_IDLE) && SHF_START;

  shf_step #(.WIDTH(WIDTH)) u_step (
    .i_r    (r_data),
    .i_c    (r_flag[FLG_CF]),
    .i_of   (r_flag[FLG_OF]),
    .i_mode (r_mode),
    .o_r    (w_r),
    .o_c    (w_c),
    .o_of   (w_of)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: a zero count skips RUN and reports done immediately.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (SHF_START) begin
          if (SHF_TIMES == '0) w_state_nxt = ST_DONE;
          else                 w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == CNT_W'(1)) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture on accepted start, then one step per RUN cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_data <= '0;
      r_flag <= '0;
      r_cnt  <= '0;
      r_mode <= '0;
    end else if (w_accept) begin
      r_data <= SHF_IN;
      r_flag <= SHF_FLAG_in;
      // SAL accumulates OF from a clean slate, but a zero count must
      // return the input flags untouched.
      if (SHF_MODE == SHF_SAL && SHF_TIMES != '0) r_flag[FLG_OF] <= 1'b0;
      r_cnt  <= SHF_TIMES;
      r_mode <= SHF_MODE;
    end else if (r_state == ST_RUN) begin
      r_data         <= w_r;
      r_flag[FLG_CF] <= w_c;
      r_flag[FLG_OF] <= w_of;
      r_cnt          <= r_cnt - CNT_W'(1);
    end
  end

  assign SHF_BUSY     = (r_state != ST_IDLE);
  assign SHF_DONE     = (r_state == ST_DONE);
  assign SHF_OUT      = r_data;
  assign SHF_FLAG_out = r_flag;

endmodule

// File: tb/tb_shf_iter.sv
// Bench for shf_iter: directed vector table, randomized operations against a
// whole-count arithmetic model, and hand sequences for handshake corners.
module tb_shf_iter;

  logic        CLK;
  logic        RST_N;
  logic        SHF_START;
  logic [15:0] SHF_IN;
  logic [3:0]  SHF_TIMES;
  logic [3:0]  SHF_MODE;
  logic [15:0] SHF_FLAG_in;
  logic        SHF_BUSY;
  logic        SHF_DONE;
  logic [15:0] SHF_OUT;
  logic [15:0] SHF_FLAG_out;

  int errors = 0;
  int checks = 0;

  shf_iter #(.WIDTH(16), .CNT_W(4)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .SHF_START    (SHF_START),
    .SHF_IN       (SHF_IN),
    .SHF_TIMES    (SHF_TIMES),
    .SHF_MODE     (SHF_MODE),
    .SHF_FLAG_in  (SHF_FLAG_in),
    .SHF_BUSY     (SHF_BUSY),
    .SHF_DONE     (SHF_DONE),
    .SHF_OUT      (SHF_OUT),
    .SHF_FLAG_out (SHF_FLAG_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  mode;
    logic [3:0]  times;
    logic [15:0] din;
    logic [15:0] fin;
    logic [15:0] eout;
    logic [15:0] eflag;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Whole-operation reference: applies the full count at once with wide
  // arithmetic. Returns {flags, result}.
  function automatic logic [31:0] ref_model(input logic [15:0] din, input int n,
                                            input logic [3:0] m, input logic [15:0] f);
    logic [31:0] w;
    logic [31:0] u;
    logic [16:0] v;
    logic [15:0] o;
    logic [15:0] fl;
    int          top;
    o  = din;
    fl = f;
    if (n == 0) return {f, din};
    w = {16'h0, din};
    u = {15'h0, f[15], din};
    case (m)
      4'd0: o = 16'(w << n);
      4'd1: o = din >> n;
      4'd2: begin w = w << n; o = w[15:0]; fl[15] = w[16]; end
      4'd3: begin o = din >> n; fl[15] = din[n-1]; end
      4'd4: begin
        w = w << n; o = w[15:0]; fl[15] = w[16];
        top = int'(din >> (15 - n));
        fl[13] = !(top == 0 || top == ((1 << (n + 1)) - 1));
      end
      4'd5: begin o = 16'($signed(din) >>> n); fl[15] = din[n-1]; fl[13] = 1'b0; end
      4'd6: o = 16'((w << n) | (w >> (16 - n)));
      4'd7: o = 16'((w >> n) | (w << (16 - n)));
      4'd8: begin v = 17'((u << n) | (u >> (17 - n))); o = v[15:0]; fl[15] = v[16]; end
      4'd9: begin v = 17'((u >> n) | (u << (17 - n))); o = v[15:0]; fl[15] = v[16]; end
      default: ;
    endcase
    return {fl, o};
  endfunction

  // Launch one operation and wait (bounded) for DONE; lat counts negedges
  // after the accepting edge, -1 on timeout. Also confirms DONE is one cycle.
  task automatic do_op(input logic [3:0] m, input logic [3:0] t, input logic [15:0] din,
                       input logic [15:0] f, output logic [15:0] o,
                       output logic [15:0] fo, output int lat);
    @(negedge CLK);
    SHF_MODE = m; SHF_TIMES = t; SHF_IN = din; SHF_FLAG_in = f; SHF_START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    SHF_START = 1'b0;
    lat = -1; o = '0; fo = '0;
    for (int j = 0; j < 40; j++) begin
      if (SHF_DONE) begin
        lat = j; o = SHF_OUT; fo = SHF_FLAG_out;
        break;
      end
      @(negedge CLK);
    end
    if (lat >= 0) begin
      @(negedge CLK);
      check("done_pulse_width", {30'h0, SHF_DONE, SHF_BUSY}, 32'h0);
    end
  endtask

  vec_t vecs[11];
  logic [15:0] o, fo;
  logic [31:0] exp;
  int lat;

  initial begin
    vecs[0]  = '{4'd0, 4'd1,  16'h8001, 16'h0000, 16'h0002, 16'h0000};
    vecs[1]  = '{4'd2, 4'd1,  16'h8001, 16'h0000, 16'h0002, 16'h8000};
    vecs[2]  = '{4'd3, 4'd2,  16'h0003, 16'h0000, 16'h0000, 16'h8000};
    vecs[3]  = '{4'd9, 4'd2,  16'h0001, 16'h8000, 16'hC000, 16'h0000};
    vecs[4]  = '{4'd4, 4'd1,  16'h4000, 16'h0000, 16'h8000, 16'h2000};
    vecs[5]  = '{4'd5, 4'd3,  16'h8000, 16'h2000, 16'hF000, 16'h0000};
    vecs[6]  = '{4'd6, 4'd15, 16'h8001, 16'h0000, 16'hC000, 16'h0000};
    vecs[7]  = '{4'd4, 4'd0,  16'h1234, 16'hFFFF, 16'h1234, 16'hFFFF};
    vecs[8]  = '{4'd15,4'd5,  16'h1234, 16'h5A5A, 16'h1234, 16'h5A5A};
    vecs[9]  = '{4'd8, 4'd1,  16'h8000, 16'h0000, 16'h0000, 16'h8000};
    vecs[10] = '{4'd1, 4'd4,  16'hFFFF, 16'h7FFF, 16'h0FFF, 16'h7FFF};

    RST_N = 1'b0; SHF_START = 1'b0; SHF_IN = '0; SHF_TIMES = '0;
    SHF_MODE = '0; SHF_FLAG_in = '0;
    repeat (3) @(negedge CLK);
    check("reset_out",  {16'h0, SHF_OUT}, 32'h0);
    check("reset_flag", {16'h0, SHF_FLAG_out}, 32'h0);
    check("reset_ctl",  {30'h0, SHF_BUSY, SHF_DONE}, 32'h0);
    RST_N = 1'b1;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].mode, vecs[i].times, vecs[i].din, vecs[i].fin, o, fo, lat);
      check($sformatf("vec%0d_lat", i), lat, {28'h0, vecs[i].times});
      check($sformatf("vec%0d_out", i), {16'h0, o}, {16'h0, vecs[i].eout});
      check($sformatf("vec%0d_flag", i), {16'h0, fo}, {16'h0, vecs[i].eflag});
    end

    // Randomized operations against the whole-count model
    for (int i = 0; i < 150; i++) begin
      logic [3:0]  m, t;
      logic [15:0] din, f;
      m = 4'($urandom_range(0, 15)); t = 4'($urandom_range(0, 15));
      din = 16'($urandom); f = 16'($urandom);
      exp = ref_model(din, int'(t), m, f);
      do_op(m, t, din, f, o, fo, lat);
      check($sformatf("rnd%0d_lat m%0d", i, m), lat, {28'h0, t});
      check($sformatf("rnd%0d_res m%0d t%0d in%0h f%0h", i, m, t, din, f), {fo, o}, exp);
    end

    // Intermediate step visibility: RCR of 0x0001 with CF=1, two steps
    @(negedge CLK);
    SHF_MODE = 4'd9; SHF_TIMES = 4'd2; SHF_IN = 16'h0001; SHF_FLAG_in = 16'h8000;
    SHF_START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    SHF_START = 1'b0;
    check("rcr_captured", {SHF_FLAG_out, SHF_OUT}, {16'h8000, 16'h0001});
    @(negedge CLK);
    check("rcr_step1", {SHF_FLAG_out, SHF_OUT}, {16'h8000, 16'h8000});
    check("rcr_step1_busy", {31'h0, SHF_BUSY}, 32'h1);
    @(negedge CLK);
    check("rcr_final", {SHF_FLAG_out, SHF_OUT, 15'h0, SHF_DONE}, {16'h0000, 16'hC000, 16'h1});
    @(negedge CLK);
    check("rcr_held", {SHF_FLAG_out, SHF_OUT}, {16'h0000, 16'hC000});

    // Start pulsed during RUN is ignored
    @(negedge CLK);
    SHF_MODE = 4'd6; SHF_TIMES = 4'd15; SHF_IN = 16'h8001; SHF_FLAG_in = 16'h0000;
    SHF_START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    SHF_START = 1'b0;
    repeat (3) @(negedge CLK);
    SHF_MODE = 4'd0; SHF_TIMES = 4'd1; SHF_IN = 16'hFFFF; SHF_FLAG_in = 16'hFFFF;
    SHF_START = 1'b1;
    @(negedge CLK);
    SHF_START = 1'b0;
    lat = -1;
    for (int j = 4; j < 40; j++) begin
      if (SHF_DONE) begin lat = j; break; end
      @(negedge CLK);
    end
    check("busy_start_lat", lat, 32'd15);
    check("busy_start_res", {SHF_FLAG_out, SHF_OUT}, {16'h0000, 16'hC000});
    @(negedge CLK);
    check("busy_start_no_requeue", {30'h0, SHF_BUSY, SHF_DONE}, 32'h0);

    // Reset mid-RUN aborts with no DONE
    @(negedge CLK);
    SHF_MODE = 4'd1; SHF_TIMES = 4'd10; SHF_IN = 16'hFFFF; SHF_FLAG_in = 16'hA5A5;
    SHF_START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    SHF_START = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("abort_out", {SHF_FLAG_out, SHF_OUT}, 32'h0);
    check("abort_ctl", {30'h0, SHF_BUSY, SHF_DONE}, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    lat = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge CLK);
      if (SHF_DONE || SHF_BUSY) lat = 1;
    end
    check("abort_no_done", lat, 32'd0);

    // New start after reset
    do_op(4'd2, 4'd3, 16'h2001, 16'h0000, o, fo, lat);
    exp = ref_model(16'h2001, 3, 4'd2, 16'h0000);
    check("post_reset_lat", lat, 32'd3);
    check("post_reset_res", {fo, o}, exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
